// File: rtl/buzzer_pkg.sv
// Shared constants and types for the buzzer peripheral: register offsets,
// CTRL/STATUS bit positions and the playback FSM state type.
package buzzer_pkg;

  // Word offsets (HADDR[4:2])
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_HALF_PER = 3'd1;
  localparam logic [2:0] OFF_DURATION = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_REMAIN   = 3'd4;
  localparam logic [2:0] OFF_IRQ_MASK = 3'd5;

  // CTRL bit indices
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_START  = 1;
  localparam int unsigned CTRL_REPEAT = 2;

  // STATUS bit indices
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } buzz_state_e;

endpackage

// File: rtl/buzzer_if.sv
// AHB-Lite signal bundle between a bus master and the buzzer slave.
interface buzzer_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/buzzer_tone_gen.sv
// Half-period divider producing the buzzer square wave. load starts a new
// wave high with a cleared counter; enable low forces the output low.
module buzzer_tone_gen #(
  parameter int unsigned HP_W = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            enable_i,
  input  logic [HP_W-1:0] half_period_i,
  output logic            buzzer_o
);

  logic [HP_W-1:0] cnt_q;
  logic [HP_W-1:0] limit;

  // eff_hp - 1 with eff_hp = max(half_period, 1); >= covers a shrunk half period
  assign limit = (half_period_i == '0) ? '0 : half_period_i - HP_W'(1);

  // Divider counter and output toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      buzzer_o <= 1'b0;
    end else if (load_i) begin
      cnt_q    <= '0;
      buzzer_o <= 1'b1;
    end else if (!enable_i) begin
      cnt_q    <= '0;
      buzzer_o <= 1'b0;
    end else if (cnt_q >= limit) begin
      cnt_q    <= '0;
      buzzer_o <= ~buzzer_o;
    end else begin
      cnt_q    <= cnt_q + HP_W'(1);
    end
  end

endmodule

// File: rtl/buzzer_interface.sv
// AHB-Lite piezo buzzer peripheral: register file, duration counter and
// playback FSM; tone waveform comes from buzzer_tone_gen.
// Optional macro BUZZER_IRQ_EN adds IRQ_MASK (offset 5) and buzzer_irq.
module buzzer_interface
  import buzzer_pkg::*;
#(
  parameter int unsigned HP_W  = 17,
  parameter int unsigned DUR_W = 22
) (
  input  logic     HCLK,
  input  logic     HRESET,
  buzzer_if.slave  ahb,
  output logic     buzzer_out
`ifdef BUZZER_IRQ_EN
  ,
  output logic     buzzer_irq
`endif
);

  logic [2:0]       addr_q;
  logic             write_q, valid_q;
  logic             en_q, repeat_q, done_q, done_d;
  logic [HP_W-1:0]  hp_q;
  logic [DUR_W-1:0] dur_q, remain_q, remain_d;
  buzz_state_e      state_q, state_d;
  logic             wr_en, wr_ctrl, wr_status, start_req, abort, done_set, load;
  logic             unused_bits;

  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign unused_bits   = ^{ahb.HSIZE, ahb.HPROT, ahb.HADDR, ahb.HTRANS, ahb.HWDATA};

  // Address-phase capture
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
      if (ahb.HSEL & ahb.HREADY & ahb.HTRANS[1]) begin
        addr_q  <= ahb.HADDR[4:2];
        write_q <= ahb.HWRITE;
      end
    end
  end

  assign wr_en     = valid_q & write_q;
  assign wr_ctrl   = wr_en & (addr_q == OFF_CTRL);
  assign wr_status = wr_en & (addr_q == OFF_STATUS);
  assign start_req = wr_ctrl & ahb.HWDATA[CTRL_START] & ahb.HWDATA[CTRL_EN];
  assign abort     = wr_ctrl & ~ahb.HWDATA[CTRL_EN] & (state_q == RUN);

  // Next state, remaining count, DONE set and waveform load
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    done_set = 1'b0;
    load     = 1'b0;
    if (start_req) begin
      if (dur_q == '0) begin
        state_d  = IDLE;
        remain_d = '0;
        done_set = 1'b1;
      end else begin
        state_d  = RUN;
        remain_d = dur_q;
        load     = 1'b1;
      end
    end else if (abort) begin
      state_d  = IDLE;
      remain_d = '0;
    end else if (state_q == RUN) begin
      if (remain_q == DUR_W'(1)) begin
        done_set = 1'b1;
        // a repeat reload keeps the tone generator running, so phase is continuous
        if (repeat_q && (dur_q != '0)) begin
          remain_d = dur_q;
        end else begin
          state_d  = IDLE;
          remain_d = '0;
        end
      end else begin
        remain_d = remain_q - DUR_W'(1);
      end
    end
  end

  // DONE: set has priority over write-1-to-clear
  assign done_d = done_set | (done_q & ~(wr_status & ahb.HWDATA[STAT_DONE]));

  // FSM and register state
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= IDLE;
      remain_q <= '0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      repeat_q <= 1'b0;
      hp_q     <= '0;
      dur_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      if (wr_ctrl) begin
        en_q     <= ahb.HWDATA[CTRL_EN];
        repeat_q <= ahb.HWDATA[CTRL_REPEAT];
      end
      if (wr_en && (addr_q == OFF_HALF_PER)) hp_q  <= ahb.HWDATA[HP_W-1:0];
      if (wr_en && (addr_q == OFF_DURATION)) dur_q <= ahb.HWDATA[DUR_W-1:0];
    end
  end

`ifdef BUZZER_IRQ_EN
  logic irq_mask_q;

  // IRQ mask register
  always_ff @(posedge HCLK) begin
    if (HRESET) irq_mask_q <= 1'b0;
    else if (wr_en && (addr_q == OFF_IRQ_MASK)) irq_mask_q <= ahb.HWDATA[0];
  end

  assign buzzer_irq = done_q & irq_mask_q;
`endif

  // Read data mux on the latched address
  always_comb begin
    ahb.HRDATA = '0;
    case (addr_q)
      OFF_CTRL: begin
        ahb.HRDATA[CTRL_EN]     = en_q;
        ahb.HRDATA[CTRL_REPEAT] = repeat_q;
      end
      OFF_HALF_PER: ahb.HRDATA[HP_W-1:0]  = hp_q;
      OFF_DURATION: ahb.HRDATA[DUR_W-1:0] = dur_q;
      OFF_STATUS: begin
        ahb.HRDATA[STAT_BUSY] = (state_q == RUN);
        ahb.HRDATA[STAT_DONE] = done_q;
      end
      OFF_REMAIN: ahb.HRDATA[DUR_W-1:0] = remain_q;
`ifdef BUZZER_IRQ_EN
      OFF_IRQ_MASK: ahb.HRDATA[0] = irq_mask_q;
`endif
      default: ahb.HRDATA = '0;
    endcase
  end

  buzzer_tone_gen #(.HP_W(HP_W)) u_tone (
    .clk          (HCLK),
    .rst          (HRESET),
    .load_i       (load),
    .enable_i     (state_d == RUN),
    .half_period_i(hp_q),
    .buzzer_o     (buzzer_out)
  );

endmodule

// File: tb/tb_buzzer_interface.sv
// Directed self-checking bench for buzzer_interface.
module tb_buzzer_interface;

  localparam logic [31:0] A_CTRL = 32'h00, A_HP = 32'h04, A_DUR = 32'h08;
  localparam logic [31:0] A_STAT = 32'h0C, A_REM = 32'h10, A_MASK = 32'h14;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic buzzer_out;
`ifdef BUZZER_IRQ_EN
  logic buzzer_irq;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  buzzer_if bus();

  buzzer_interface #(.HP_W(17), .DUR_W(22)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .ahb       (bus),
    .buzzer_out(buzzer_out)
`ifdef BUZZER_IRQ_EN
    ,
    .buzzer_irq(buzzer_irq)
`endif
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
  endtask

  // Write; optionally leave a read address phase of rd_a pending in the data phase
  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d,
                           input bit rd_next, input logic [31:0] rd_a);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = a;
    @(posedge HCLK); #1;
    bus.HWDATA = d;
    if (rd_next) begin
      bus.HWRITE = 1'b0;
      bus.HADDR  = rd_a;
    end else begin
      bus_idle();
    end
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = a;
    @(posedge HCLK); #1;
    bus_idle();
    d = bus.HRDATA;
  endtask

  initial begin
    logic [31:0] rd;
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HSIZE = 3'b010;
    bus.HPROT = 4'b0011; bus.HWRITE = 1'b0; bus.HWDATA = '0; bus.HREADY = 1'b1;

    // Reset state
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      ahb_read(32'(k * 4), rd);
      check($sformatf("reset_rd%0d", k), rd, 32'h0);
    end
    check("reset_buzz", {31'b0, buzzer_out}, 32'h0);
    check("hreadyout", {31'b0, bus.HREADYOUT}, 32'h1);
    check("hresp", {31'b0, bus.HRESP}, 32'h0);

    // Single burst: HP=4, DUR=16
    ahb_write(A_HP, 32'd4, 0, '0);
    ahb_write(A_DUR, 32'd16, 0, '0);
    ahb_write(A_CTRL, 32'h3, 1, A_STAT);
    for (int i = 0; i < 20; i++) begin
      @(posedge HCLK); #1;
      check($sformatf("burst_buzz%0d", i), {31'b0, buzzer_out},
            {31'b0, (i < 16) && ((i / 4) % 2 == 0)});
      check($sformatf("burst_stat%0d", i), bus.HRDATA, (i < 16) ? 32'h1 : 32'h2);
    end
    bus_idle();

    // W1C of DONE
    ahb_write(A_STAT, 32'h2, 0, '0);
    ahb_read(A_STAT, rd);
    check("w1c_done", rd, 32'h0);

    // Repeat mode: HP=2, DUR=6
    ahb_write(A_HP, 32'd2, 0, '0);
    ahb_write(A_DUR, 32'd6, 0, '0);
    ahb_write(A_CTRL, 32'h7, 1, A_REM);
    for (int i = 0; i < 14; i++) begin
      @(posedge HCLK); #1;
      check($sformatf("rep_buzz%0d", i), {31'b0, buzzer_out}, {31'b0, (i / 2) % 2 == 0});
      check($sformatf("rep_remain%0d", i), bus.HRDATA, 32'(6 - (i % 6)));
    end
    ahb_read(A_CTRL, rd);
    check("ctrl_readback", rd, 32'h5);

    // Abort mid-burst by clearing EN
    ahb_write(A_CTRL, 32'h0, 1, A_STAT);
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK); #1;
      check($sformatf("abort_buzz%0d", i), {31'b0, buzzer_out}, 32'h0);
      check($sformatf("abort_stat%0d", i), bus.HRDATA, 32'h2);
    end
    bus_idle();
    ahb_read(A_REM, rd);
    check("abort_remain", rd, 32'h0);

    // DURATION=0 start: immediate DONE, no tone
    ahb_write(A_STAT, 32'h2, 0, '0);
    ahb_read(A_STAT, rd);
    check("w1c_done2", rd, 32'h0);
    ahb_write(A_DUR, 32'd0, 0, '0);
    ahb_write(A_CTRL, 32'h3, 1, A_STAT);
    for (int i = 0; i < 4; i++) begin
      @(posedge HCLK); #1;
      check($sformatf("dur0_buzz%0d", i), {31'b0, buzzer_out}, 32'h0);
      check($sformatf("dur0_stat%0d", i), bus.HRDATA, 32'h2);
    end
    bus_idle();

    // HALF_PERIOD=0: toggle every cycle, DUR=5
    ahb_write(A_STAT, 32'h2, 0, '0);
    ahb_write(A_DUR, 32'd5, 0, '0);
    ahb_write(A_HP, 32'd0, 0, '0);
    ahb_write(A_CTRL, 32'h3, 1, A_STAT);
    for (int i = 0; i < 7; i++) begin
      @(posedge HCLK); #1;
      check($sformatf("hp0_buzz%0d", i), {31'b0, buzzer_out},
            {31'b0, (i < 5) && (i % 2 == 0)});
      check($sformatf("hp0_stat%0d", i), bus.HRDATA, (i < 5) ? 32'h1 : 32'h2);
    end
    bus_idle();

    // START with EN=0 is ignored
    ahb_write(A_STAT, 32'h2, 0, '0);
    ahb_write(A_CTRL, 32'h2, 1, A_STAT);
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK); #1;
      check($sformatf("noen_buzz%0d", i), {31'b0, buzzer_out}, 32'h0);
      check($sformatf("noen_stat%0d", i), bus.HRDATA, 32'h0);
    end
    bus_idle();

    // Undecoded offset reads 0
    ahb_write(32'h18, 32'hFFFF_FFFF, 0, '0);
    ahb_read(32'h18, rd);
    check("undecoded_rd", rd, 32'h0);

    // Reset mid-run
    ahb_write(A_HP, 32'd3, 0, '0);
    ahb_write(A_DUR, 32'd100, 0, '0);
    ahb_write(A_CTRL, 32'h3, 0, '0);
    repeat (2) @(posedge HCLK);
    #1 check("prerst_buzz", {31'b0, buzzer_out}, 32'h1);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    check("rst_buzz", {31'b0, buzzer_out}, 32'h0);
    HRESET = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      ahb_read(32'(k * 4), rd);
      check($sformatf("rst_rd%0d", k), rd, 32'h0);
    end

`ifdef BUZZER_IRQ_EN
    ahb_write(A_MASK, 32'h1, 0, '0);
    ahb_read(A_MASK, rd);
    check("mask_rd", rd, 32'h1);
    check("irq_low", {31'b0, buzzer_irq}, 32'h0);
    ahb_write(A_CTRL, 32'h3, 0, '0);
    @(posedge HCLK); #1;
    check("irq_rise", {31'b0, buzzer_irq}, 32'h1);
    ahb_write(A_STAT, 32'h2, 0, '0);
    @(posedge HCLK); #1;
    check("irq_fall", {31'b0, buzzer_irq}, 32'h0);
`else
    ahb_write(A_MASK, 32'h1, 0, '0);
    ahb_read(A_MASK, rd);
    check("off5_rd", rd, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
